icache_dm: RTL and testbench
============================

Name: icache_dm

Overview:
- Direct-mapped instruction cache between the core's fetch port (pc_reg / if_id side) and a slower external instruction memory.
- Hits return the instruction in the same cycle, so it is a drop-in for the combinational instruction ROM.
- Misses raise a stall request and refill one line from memory using a per-word req/ack handshake.
- Lets the pipeline run from a slower external memory without changing the IF/ID timing contract.

Parameters:
- INDEX_BITS, 6: log2 of line count (64 lines).
- LINE_WORDS, 4: 32-bit words per line; power of 2, at least 2.
- Derived: OFFSET_BITS = log2(LINE_WORDS) + 2.
- Derived: TAG_BITS = 32 - INDEX_BITS - OFFSET_BITS.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; one clock; asynchronous, active-low (rst = 0 resets).
- ce_i  in  1  fetch enable from pc_reg.
- addr_i  in  32  fetch byte address; bits [1:0] ignored.
- flush_i  in  1  invalidate all lines (synchronous, single-cycle pulse or level).
- inst_o  out  32  fetched instruction.
- inst_valid_o  out  1  inst_o is valid this cycle.
- stallreq_o  out  1  stall request to pipeline control.
- mem_req_o  out  1  refill word request.
- mem_addr_o  out  32  word address of the current refill beat.
- mem_ack_i  in  1  memory returns mem_data_i this cycle.
- mem_data_i  in  32  refill data.

Behaviour:
- Address split: tag = addr_i[31:32-TAG_BITS]; index = next INDEX_BITS bits; word = addr_i[OFFSET_BITS-1:2].
- Storage:
  - valid[] flops, asynchronously reset to 0.
  - tag and data arrays have no reset.
- Reset values: state IDLE, beat counter 0, mem_req_o 0, mem_addr_o 0, inst_o 0, inst_valid_o 0, stallreq_o 0, refill flush-pending flag 0.
- Reset mid-refill: the request is dropped immediately and the partial line is never validated.
- Lookup is combinational in IDLE when ce_i = 1: hit = valid[index] && tag match.
- ce_i = 0: inst_o = 0, inst_valid_o = 0, stallreq_o = 0, no state change, even on a would-be miss.
- Hit in IDLE: inst_o = data[index][word], inst_valid_o = 1, stallreq_o = 0, zero-cycle latency.
- Miss in IDLE:
  - stallreq_o = 1, inst_valid_o = 0, inst_o = 0.
  - Latch the line base (addr_i with offset bits cleared); beat = 0; next state REFILL.
- REFILL:
  - mem_req_o = 1 continuously; mem_addr_o = line base + beat*4.
  - On mem_ack_i: write mem_data_i to data[index][beat], beat++.
  - Ack on beat LINE_WORDS-1 -> UPDATE.
  - No ack: hold address, no timeout.
  - addr_i is ignored during refill because the core is stalled.
- UPDATE:
  - Write the tag; set valid[index] = 1 unless flush-pending is set.
  - Clear flush-pending; mem_req_o = 0; next state IDLE.
- stallreq_o = 1 in REFILL and UPDATE; inst_valid_o = 0 in both.
- Miss timing with ack every cycle: stallreq_o high for 1 + LINE_WORDS + 1 = 6 cycles; the hit is served in the 7th cycle.
- flush_i:
  - In IDLE: clears all valid bits at the clock edge. A lookup in that same cycle still uses the pre-flush valid bits.
  - In REFILL or UPDATE: clears all valid bits and sets flush-pending.
  - The refill still completes all beats, but the line is not validated, so the next lookup misses again.
- Simultaneous flush_i and UPDATE: flush wins and the line stays invalid.
- A refill for an index overwrites the previous line for that index (conflict eviction); no write path from the core.

Decomposition:
- Shared package / defines: cache geometry constants (INDEX_BITS, LINE_WORDS, derived widths); FSM state encodings (IDLE, REFILL, UPDATE); ZeroWord reuse.
- One sub-module, icache_ram: tag + data arrays, single write port, combinational read, no reset.
- The top level holds valid bits, the FSM, the beat counter and the handshake.

Test Plan:
- Cold miss: reset, ce_i = 1, addr_i = 0x0000_0000, memory acks every cycle with 0x3401_1100, 0x3402_0020, 0x3403_ff00, 0x3404_ffff.
  - Expect mem_addr_o 0x0, 0x4, 0x8, 0xC.
  - Expect stallreq_o high exactly 6 cycles, then inst_o = 0x3401_1100 with inst_valid_o = 1.
- Hit sequence: after the cold fill, addr_i = 0x4, 0x8, 0xC on consecutive cycles.
  - Expect 0x3402_0020, 0x3403_ff00, 0x3404_ffff, stallreq_o = 0, mem_req_o = 0.
- Conflict eviction: fetch 0x0000_0400 (index 0, tag 1).
  - Expect a refill from 0x400..0x40C.
  - A subsequent fetch of 0x0000_0000 misses again.
- Slow memory: ack every 3rd cycle.
  - mem_addr_o holds each beat for 3 cycles.
  - stallreq_o high for 1 + 12 + 1 = 14 cycles; correct data afterwards.
- Flush during refill: assert flush_i on the 2nd REFILL cycle.
  - All beats complete, but the same address misses again after UPDATE.
  - A flush pulse in IDLE makes a prior hit at 0x4 miss.
- Reset mid-refill: drive rst = 0 during beat 2.
  - mem_req_o drops to 0 asynchronously; after release, 0x0 misses and refill restarts at beat 0.
  - ce_i = 0 at any time gives inst_o = 0, inst_valid_o = 0, stallreq_o = 0.

Source files
------------

// File: rtl/icache_dm_pkg.sv
// Shared geometry, state encoding and constants for the direct-mapped instruction cache.
// All derived widths follow from INDEX_BITS and LINE_WORDS.
package icache_dm_pkg;

  localparam int INDEX_BITS  = 6;
  localparam int LINE_WORDS  = 4;
  localparam int WORD_BITS   = $clog2(LINE_WORDS);
  localparam int OFFSET_BITS = WORD_BITS + 2;
  localparam int TAG_BITS    = 32 - INDEX_BITS - OFFSET_BITS;
  localparam int LINES       = 1 << INDEX_BITS;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    UPDATE = 2'd2
  } state_t;

endpackage

// File: rtl/icache_dm_ram.sv
// Tag and data arrays for icache_dm: combinational read, one synchronous write port, no reset.
// Data words are addressed as {index, word}.
module icache_dm_ram
  import icache_dm_pkg::*;
(
  input  logic                  clk,
  input  logic [INDEX_BITS-1:0] rd_index,
  input  logic [WORD_BITS-1:0]  rd_word,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [31:0]           rd_data,
  input  logic                  data_we,
  input  logic                  tag_we,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [WORD_BITS-1:0]  wr_word,
  input  logic [31:0]           wr_data,
  input  logic [TAG_BITS-1:0]   wr_tag
);

  logic [TAG_BITS-1:0] tag_mem  [LINES];
  logic [31:0]         data_mem [LINES*LINE_WORDS];

  assign rd_tag  = tag_mem[rd_index];
  assign rd_data = data_mem[{rd_index, rd_word}];

  always_ff @(posedge clk) begin
    if (data_we) data_mem[{wr_index, wr_word}] <= wr_data;
    if (tag_we)  tag_mem[wr_index] <= wr_tag;
  end

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache: same-cycle hits, stall + per-word req/ack refill on a miss.
// Holds the valid bits, refill FSM (IDLE -> REFILL -> UPDATE), beat counter and handshake.
module icache_dm
  import icache_dm_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic [31:0] addr_i,
  input  logic        flush_i,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  output logic        stallreq_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i
);

  // Handshake: mem_req_o stays high with a stable mem_addr_o until the memory
  // answers with mem_ack_i, which also qualifies mem_data_i in that same cycle.

  state_t                   state, next_state;
  logic [WORD_BITS-1:0]     beat;
  logic [31-OFFSET_BITS:0]  line_q;   // {tag, index} of the line being refilled
  logic [LINES-1:0]         valid;
  logic                     flush_pend;

  logic [TAG_BITS-1:0]      lk_tag, rd_tag;
  logic [INDEX_BITS-1:0]    lk_index, fill_index;
  logic [WORD_BITS-1:0]     lk_word;
  logic [31:0]              rd_data;
  logic                     hit, miss_start, last_beat;
  logic                     unused_bits;

  assign lk_tag      = addr_i[31 -: TAG_BITS];
  assign lk_index    = addr_i[OFFSET_BITS +: INDEX_BITS];
  assign lk_word     = addr_i[2 +: WORD_BITS];
  assign unused_bits = ^addr_i[1:0];
  assign fill_index  = line_q[INDEX_BITS-1:0];

  assign hit        = valid[lk_index] && (rd_tag == lk_tag);
  assign miss_start = (state == IDLE) && ce_i && !hit;
  assign last_beat  = (beat == WORD_BITS'(LINE_WORDS - 1));

  icache_dm_ram u_ram (
    .clk      (clk),
    .rd_index (lk_index),
    .rd_word  (lk_word),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .data_we  ((state == REFILL) && mem_ack_i),
    .tag_we   (state == UPDATE),
    .wr_index (fill_index),
    .wr_word  (beat),
    .wr_data  (mem_data_i),
    .wr_tag   (line_q[INDEX_BITS +: TAG_BITS])
  );

  always_comb begin
    next_state   = state;
    inst_o       = ZERO_WORD;
    inst_valid_o = 1'b0;
    stallreq_o   = 1'b0;
    mem_req_o    = 1'b0;
    mem_addr_o   = ZERO_WORD;
    case (state)
      IDLE: begin
        if (ce_i) begin
          if (hit) begin
            inst_o       = rd_data;
            inst_valid_o = 1'b1;
          end else begin
            stallreq_o = 1'b1;
            next_state = REFILL;
          end
        end
      end
      REFILL: begin
        stallreq_o = 1'b1;
        mem_req_o  = 1'b1;
        mem_addr_o = {line_q, beat, 2'b00};
        if (mem_ack_i && last_beat) next_state = UPDATE;
      end
      UPDATE: begin
        stallreq_o = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      beat       <= '0;
      line_q     <= '0;
      valid      <= '0;
      flush_pend <= 1'b0;
    end else begin
      state <= next_state;
      if (miss_start) begin
        line_q <= addr_i[31:OFFSET_BITS];
        beat   <= '0;
      end else if ((state == REFILL) && mem_ack_i) begin
        beat <= beat + 1'b1;
      end
      // A flush during a refill must outlive the refill so the line is not validated.
      if (state == UPDATE) flush_pend <= 1'b0;
      else if (flush_i && (state == REFILL)) flush_pend <= 1'b1;
      if (flush_i) valid <= '0;
      else if ((state == UPDATE) && !flush_pend) valid[fill_index] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: scripted fetches against a req/ack memory responder,
// expected instructions queued at drive time and popped when the cache returns a hit.
module tb_icache_dm;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce_i;
  logic [31:0] addr_i;
  logic        flush_i;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic        stallreq_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_data_i;

  int tests_run    = 0;
  int tests_failed = 0;
  int ack_gap      = 1;

  logic [31:0] exp_q[$];
  logic [31:0] addr_log[$];
  int          beat_len_q[$];

  icache_dm dut (
    .clk          (clk),
    .rst          (rst),
    .ce_i         (ce_i),
    .addr_i       (addr_i),
    .flush_i      (flush_i),
    .inst_o       (inst_o),
    .inst_valid_o (inst_valid_o),
    .stallreq_o   (stallreq_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_ack_i    (mem_ack_i),
    .mem_data_i   (mem_data_i)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'h3401_1100;
      32'h0000_0004: mem_word = 32'h3402_0020;
      32'h0000_0008: mem_word = 32'h3403_ff00;
      32'h0000_000C: mem_word = 32'h3404_ffff;
      default:       mem_word = (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  // memory responder: acks on the ack_gap-th cycle of each beat, logs beat addresses
  initial begin : responder
    int          wait_cnt;
    logic [31:0] beat_addr;
    wait_cnt   = 0;
    beat_addr  = 0;
    mem_ack_i  = 1'b0;
    mem_data_i = 32'h0;
    forever begin
      @(negedge clk);
      mem_ack_i = 1'b0;
      if (rst && mem_req_o) begin
        if (wait_cnt == 0) beat_addr = mem_addr_o;
        if (wait_cnt == ack_gap - 1) begin
          mem_ack_i  = 1'b1;
          mem_data_i = mem_word(mem_addr_o);
          addr_log.push_back((mem_addr_o == beat_addr) ? mem_addr_o : 32'hFFFF_FFFF);
          beat_len_q.push_back(wait_cnt + 1);
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // driver: present a fetch until the cache returns an instruction
  task automatic do_fetch(input logic [31:0] a, input int fc, input int max_cyc,
                          output logic [31:0] data, output bit got, output int stalls,
                          output bit req_seen);
    data = 32'h0; got = 1'b0; stalls = 0; req_seen = 1'b0;
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      @(posedge clk); #1;
      ce_i    = 1'b1;
      addr_i  = a;
      flush_i = (cyc == fc);
      @(negedge clk);
      if (inst_valid_o) begin
        data     = inst_o;
        got      = 1'b1;
        req_seen = mem_req_o;
        break;
      end
      if (stallreq_o) stalls++;
    end
  endtask

  task automatic go_idle(input bit flush);
    @(posedge clk); #1;
    ce_i    = 1'b0;
    flush_i = flush;
    @(posedge clk); #1;
    flush_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; ce_i = 1'b0; addr_i = 32'h0; flush_i = 1'b0;
    #23;
    tests_run++;
    if ({mem_req_o, inst_valid_o, stallreq_o} !== 3'b000 || mem_addr_o !== 32'h0 || inst_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: req=%0b valid=%0b stall=%0b addr=%h inst=%h, required all zero",
               mem_req_o, inst_valid_o, stallreq_o, mem_addr_o, inst_o);
    end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  // fetch one address, check data and stall length, and the refill beat addresses when a miss is expected
  task automatic test_fetch(input string name, input logic [31:0] a, input int fc, input int exp_stalls,
                            input int exp_refills);
    logic [31:0] data, exp, base;
    bit          got, req_seen;
    int          stalls;
    addr_log.delete();
    beat_len_q.delete();
    exp_q.push_back(mem_word({a[31:2], 2'b00}));
    do_fetch(a, fc, 60, data, got, stalls, req_seen);
    tests_run++;
    if (!got) begin
      tests_failed++;
      $display("FAIL %s_timeout: no inst_valid_o for addr %h within 60 cycles", name, a);
      void'(exp_q.pop_front());
      return;
    end
    exp = exp_q.pop_front();
    tests_run++;
    if (data !== exp) begin
      tests_failed++;
      $display("FAIL %s_data: got %h, required %h", name, data, exp);
    end
    tests_run++;
    if (stalls !== exp_stalls || req_seen !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_stall: stall cycles %0d mem_req %0b, required %0d and 0", name, stalls, req_seen, exp_stalls);
    end
    tests_run++;
    if (addr_log.size() !== exp_refills * 4) begin
      tests_failed++;
      $display("FAIL %s_beats: %0d refill beats, required %0d", name, addr_log.size(), exp_refills * 4);
    end else begin
      base = {a[31:4], 4'h0};
      for (int i = 0; i < addr_log.size(); i++) begin
        tests_run++;
        if (addr_log[i] !== base + 32'(4 * (i % 4)) || beat_len_q[i] !== ack_gap) begin
          tests_failed++;
          $display("FAIL %s_beat_addr[%0d]: addr %h held %0d cycles, required %h held %0d",
                   name, i, addr_log[i], beat_len_q[i], base + 32'(4 * (i % 4)), ack_gap);
        end
      end
    end
  endtask

  task automatic test_cold_miss();
    test_fetch("cold_miss", 32'h0000_0000, -1, 6, 1);
  endtask

  task automatic test_back_to_back_hits();
    test_fetch("hit_4", 32'h0000_0004, -1, 0, 0);
    test_fetch("hit_8", 32'h0000_0008, -1, 0, 0);
    test_fetch("hit_c", 32'h0000_000C, -1, 0, 0);
  endtask

  task automatic test_conflict();
    test_fetch("conflict_fill", 32'h0000_0400, -1, 6, 1);
    test_fetch("conflict_refetch", 32'h0000_0000, -1, 6, 1);
    test_fetch("conflict_hit", 32'h0000_0008, -1, 0, 0);
  endtask

  task automatic test_slow_memory();
    ack_gap = 3;
    test_fetch("slow_fill", 32'h0000_0814, -1, 14, 1);
    ack_gap = 1;
    test_fetch("slow_hit", 32'h0000_081C, -1, 0, 0);
  endtask

  task automatic test_flush();
    // flush on the 2nd REFILL cycle: line is filled but not validated, so a second refill follows
    test_fetch("flush_refill", 32'h0000_1028, 2, 12, 2);
    test_fetch("flush_refill_hit", 32'h0000_1020, -1, 0, 0);
    // line 0 was invalidated by that flush
    test_fetch("flush_line0_miss", 32'h0000_0004, -1, 6, 1);
    // flush in the same cycle as a hit: the lookup still sees the old valid bits
    test_fetch("flush_idle_hit", 32'h0000_0004, 0, 0, 0);
    test_fetch("flush_idle_miss", 32'h0000_0004, -1, 6, 1);
  endtask

  task automatic test_reset_mid_refill();
    int n;
    go_idle(1'b1);
    addr_log.delete();
    ce_i = 1'b1; addr_i = 32'h0000_0000;
    n = 0;
    while (addr_log.size() < 2 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    tests_run++;
    if (addr_log.size() < 2) begin
      tests_failed++;
      $display("FAIL rst_mid_reach: %0d beats after %0d cycles, required 2", addr_log.size(), n);
    end
    #2;
    rst = 1'b0;
    #1;
    tests_run++;
    if (mem_req_o !== 1'b0 || mem_addr_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL rst_mid_async: mem_req %0b addr %h, required 0 and 00000000", mem_req_o, mem_addr_o);
    end
    ce_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    test_fetch("rst_mid_restart", 32'h0000_0000, -1, 6, 1);
  endtask

  task automatic test_ce_low();
    int n0;
    n0 = addr_log.size();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      ce_i    = 1'b0;
      flush_i = 1'b0;
      addr_i  = (i % 2 == 0) ? 32'h0000_0000 : {$urandom_range(16'hFFFF, 16'h0100), 16'h0};
      @(negedge clk);
      tests_run++;
      if (inst_o !== 32'h0 || inst_valid_o !== 1'b0 || stallreq_o !== 1'b0 || mem_req_o !== 1'b0) begin
        tests_failed++;
        $display("FAIL ce_low[%0d]: inst %h valid %0b stall %0b req %0b, required all zero",
                 i, inst_o, inst_valid_o, stallreq_o, mem_req_o);
      end
    end
    tests_run++;
    if (addr_log.size() !== n0) begin
      tests_failed++;
      $display("FAIL ce_low_no_refill: %0d beats logged, required %0d", addr_log.size(), n0);
    end
    test_fetch("ce_low_then_hit", 32'h0000_000C, -1, 0, 0);
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_back_to_back_hits();
    test_conflict();
    test_slow_memory();
    test_flush();
    test_reset_mid_refill();
    test_ce_low();
    go_idle(1'b0);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
